vga_trace_plotter: RTL and testbench

Parametrised multi-channel waveform overlay for the VGA pipeline: sits between the VGA timing generator / background palette lookup and the `VGA_R/G/B` pins. Once per frame, during vertical blanking, it reads per-channel min/max headers and `COLS` samples per channel from signal memory. It scales each sample into its plot box with a serial divider and stores per-column span limits in an internal trace RAM. During active video it overlays connected trace spans (no gaps between columns) and an optional grid onto the background colour.

---
 rtl/vga_trace_plotter.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_vga_trace_plotter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_trace_plotter.sv
// Multi-channel waveform overlay for the VGA pixel path; traces are rescaled from signal memory
// once per frame. Defining TRACE_GRID_EN adds a grid inside each plot box.
module vga_trace_plotter #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned COLS       = 320,
    parameter int unsigned SAMPLE_W   = 12,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned HDR_BASE   = 'h6A9,
    parameter int unsigned SIG_BASE   = 'h559,
    parameter int unsigned SIG_STRIDE = 'h154,
    parameter int unsigned BOX_X0     = 55,
    parameter int unsigned BOX_Y0     = 45,
    parameter int unsigned BOX_PITCH  = 209,
    parameter int unsigned BOX_H      = 180,
    parameter int unsigned GRID_PITCH = 20,
    parameter logic [11:0] GRID_COLOR = 12'h111
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   active,
    input  logic [9:0]             x,
    input  logic [8:0]             y,
    input  logic [11:0]            bg_color,
    input  logic [12*CHANNELS-1:0] trace_colors,
    output logic [ADDR_W-1:0]      sig_addr,
    input  logic [31:0]            sig_data,
    output logic [11:0]            pixel_color,
    output logic                   busy
);
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned ROW_W  = $clog2(BOX_H);
    localparam int unsigned NUM_W  = SAMPLE_W + $clog2(BOX_H);
    localparam int unsigned RAM_N  = CHANNELS * COLS;
    localparam int unsigned RAM_AW = $clog2(RAM_N);
    localparam int unsigned HDR_W  = $clog2(2 * CHANNELS + 1);
    localparam int unsigned DIV_W  = $clog2(NUM_W);

    typedef enum logic [2:0] {StIdle, StHdr, StFetch, StDiv, StStore} state_e;

    state_e                state_q, state_d;
    logic [HDR_W-1:0]      hdr_cnt_q, hdr_cnt_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  phase_q, phase_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [ADDR_W-1:0]     sig_addr_q, sig_addr_d;
    logic [SAMPLE_W-1:0]   rem_q, rem_d, den_q, den_d;
    logic [NUM_W-1:0]      quo_q, quo_d;
    logic [ROW_W-1:0]      r_prev_q, r_prev_d;
    logic                  trace_valid_q, trace_valid_d;
    logic [SAMPLE_W-1:0]   min_q [CHANNELS];
    logic [SAMPLE_W-1:0]   max_q [CHANNELS];

    logic                  hdr_cap, ram_we, div_ge;
    logic [RAM_AW-1:0]     ram_waddr, rd_addr;
    logic [2*ROW_W-1:0]    ram_wdata, ram_rd_q;
    logic [2*ROW_W-1:0]    trace_ram [RAM_N];
    logic [SAMPLE_W-1:0]   smp, mn, mx, clamped, den;
    logic [NUM_W-1:0]      num;
    logic [SAMPLE_W:0]     trial;
    logic [ROW_W-1:0]      q_row, r_cur, r_prev, span_lo, span_hi;
    logic [31:0]           unused_sig_bits;

    assign smp             = sig_data[SAMPLE_W-1:0];
    assign unused_sig_bits = sig_data;
    assign busy            = (state_q != StIdle);
    assign sig_addr        = sig_addr_q;

    function automatic logic [ADDR_W-1:0] sample_addr(input int unsigned c, input int unsigned k);
        return ADDR_W'(SIG_BASE + c * SIG_STRIDE + k);
    endfunction

    function automatic int unsigned box_top(input int unsigned c);
        return BOX_Y0 + c * BOX_PITCH;
    endfunction

    // Sample scaling and span computation shared by FETCH, DIV and STORE.
    always_comb begin
        mn      = min_q[ch_q];
        mx      = max_q[ch_q];
        clamped = (smp < mn) ? mn : ((smp > mx) ? mx : smp);
        num     = NUM_W'(clamped - mn) * NUM_W'(BOX_H);
        den     = (mx < mn) ? '0 : mx - mn;
        trial   = {rem_q, quo_q[NUM_W-1]};
        div_ge  = (trial >= {1'b0, den_q});
        if (den_q == '0) q_row = '0;
        else if (quo_q > NUM_W'(BOX_H - 1)) q_row = ROW_W'(BOX_H - 1);
        else q_row = quo_q[ROW_W-1:0];
        r_cur   = ROW_W'(BOX_H - 1) - q_row;
        r_prev  = (col_q == '0) ? r_cur : r_prev_q;
        span_lo = (r_prev < r_cur) ? r_prev : r_cur;
        span_hi = (r_prev < r_cur) ? r_cur : r_prev;
        if (span_lo != '0) span_lo = span_lo - ROW_W'(1);
        if (span_hi != ROW_W'(BOX_H - 1)) span_hi = span_hi + ROW_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        hdr_cnt_d     = hdr_cnt_q;
        ch_d          = ch_q;
        col_d         = col_q;
        phase_d       = phase_q;
        div_cnt_d     = div_cnt_q;
        sig_addr_d    = sig_addr_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        den_d         = den_q;
        r_prev_d      = r_prev_q;
        trace_valid_d = trace_valid_q;
        hdr_cap       = 1'b0;
        ram_we        = 1'b0;
        ram_waddr     = '0;
        ram_wdata     = '0;
        unique case (state_q)
            StIdle: begin
            end
            StHdr: begin
                // Data for header address n arrives while address n+1 is on the bus.
                hdr_cap = (hdr_cnt_q != '0);
                if (hdr_cnt_q == HDR_W'(2 * CHANNELS)) begin
                    state_d    = StFetch;
                    phase_d    = 1'b0;
                    ch_d       = '0;
                    col_d      = '0;
                    sig_addr_d = sample_addr(0, 0);
                end else begin
                    hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
                    if (hdr_cnt_q != HDR_W'(2 * CHANNELS - 1)) begin
                        sig_addr_d = ADDR_W'(HDR_BASE + 32'(hdr_cnt_q) + 1);
                    end
                end
            end
            StFetch: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d   = 1'b0;
                    state_d   = StDiv;
                    div_cnt_d = '0;
                    rem_d     = '0;
                    quo_d     = num;
                    den_d     = den;
                end
            end
            StDiv: begin
                rem_d = div_ge ? SAMPLE_W'(trial - {1'b0, den_q}) : trial[SAMPLE_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], div_ge};
                if (div_cnt_q == DIV_W'(NUM_W - 1)) state_d = StStore;
                else div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            StStore: begin
                ram_we    = 1'b1;
                ram_waddr = RAM_AW'(32'(ch_q) * COLS + 32'(col_q));
                ram_wdata = {span_lo, span_hi};
                r_prev_d  = r_cur;
                if (col_q != COL_W'(COLS - 1)) begin
                    col_d      = col_q + COL_W'(1);
                    sig_addr_d = sample_addr(32'(ch_q), 32'(col_q) + 1);
                    state_d    = StFetch;
                end else if (ch_q != CH_W'(CHANNELS - 1)) begin
                    ch_d       = ch_q + CH_W'(1);
                    col_d      = '0;
                    sig_addr_d = sample_addr(32'(ch_q) + 1, 0);
                    state_d    = StFetch;
                end else begin
                    state_d       = StIdle;
                    trace_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (frame_start) begin
            state_d       = StHdr;
            hdr_cnt_d     = '0;
            sig_addr_d    = ADDR_W'(HDR_BASE);
            trace_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            hdr_cnt_q     <= '0;
            ch_q          <= '0;
            col_q         <= '0;
            phase_q       <= 1'b0;
            div_cnt_q     <= '0;
            sig_addr_q    <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            den_q         <= '0;
            r_prev_q      <= '0;
            trace_valid_q <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                min_q[c] <= '0;
                max_q[c] <= '1;
            end
        end else begin
            state_q       <= state_d;
            hdr_cnt_q     <= hdr_cnt_d;
            ch_q          <= ch_d;
            col_q         <= col_d;
            phase_q       <= phase_d;
            div_cnt_q     <= div_cnt_d;
            sig_addr_q    <= sig_addr_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            den_q         <= den_d;
            r_prev_q      <= r_prev_d;
            trace_valid_q <= trace_valid_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (hdr_cap && hdr_cnt_q == HDR_W'(c + 1)) min_q[c] <= smp;
                if (hdr_cap && hdr_cnt_q == HDR_W'(CHANNELS + c + 1)) max_q[c] <= smp;
            end
        end
    end

    // Display pipeline: stage 1 looks up the trace RAM, stage 2 picks the colour.
    logic              hit, s1_active, s1_hit;
    logic [CH_W-1:0]   hit_ch, s1_ch;
    logic [ROW_W-1:0]  hit_row, s1_row;
    logic [COL_W-1:0]  hit_col;
    logic [11:0]       s1_bg, pixel_d, pixel_q;
    logic              on_trace, grid_px;
`ifdef TRACE_GRID_EN
    logic              hit_grid, s1_grid;
`else
    logic [11:0]       unused_grid;
    assign unused_grid = GRID_COLOR ^ 12'(GRID_PITCH);
`endif

    always_comb begin
        hit     = 1'b0;
        hit_ch  = '0;
        hit_row = '0;
        hit_col = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (active && 32'(x) >= BOX_X0 && 32'(x) < BOX_X0 + COLS &&
                32'(y) >= box_top(c) && 32'(y) < box_top(c) + BOX_H) begin
                hit     = 1'b1;
                hit_ch  = CH_W'(c);
                hit_row = ROW_W'(32'(y) - box_top(c));
                hit_col = COL_W'(32'(x) - BOX_X0);
            end
        end
        rd_addr = RAM_AW'(32'(hit_ch) * COLS + 32'(hit_col));
`ifdef TRACE_GRID_EN
        hit_grid = hit && ((32'(hit_col) % GRID_PITCH == 0) || (32'(hit_row) % GRID_PITCH == 0));
`endif
    end

    always_ff @(posedge clock) begin
        if (ram_we) trace_ram[ram_waddr] <= ram_wdata;
        ram_rd_q <= trace_ram[rd_addr];
    end

    always_comb begin
        on_trace = s1_hit && trace_valid_q && !busy &&
                   (ram_rd_q[2*ROW_W-1:ROW_W] <= s1_row) && (s1_row <= ram_rd_q[ROW_W-1:0]);
`ifdef TRACE_GRID_EN
        grid_px = s1_grid;
`else
        grid_px = 1'b0;
`endif
        pixel_d = s1_bg;
        if (!s1_active) pixel_d = '0;
        else if (on_trace) pixel_d = trace_colors[12*32'(s1_ch) +: 12];
        else if (grid_px) pixel_d = GRID_COLOR;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_active <= 1'b0;
            s1_hit    <= 1'b0;
            s1_ch     <= '0;
            s1_row    <= '0;
            s1_bg     <= '0;
            pixel_q   <= '0;
`ifdef TRACE_GRID_EN
            s1_grid   <= 1'b0;
`endif
        end else begin
            s1_active <= active;
            s1_hit    <= hit;
            s1_ch     <= hit_ch;
            s1_row    <= hit_row;
            s1_bg     <= bg_color;
            pixel_q   <= pixel_d;
`ifdef TRACE_GRID_EN
            s1_grid   <= hit_grid;
`endif
        end
    end

    assign pixel_color = pixel_q;

endmodule

// File: tb/tb_vga_trace_plotter.sv
// Scoreboard bench for vga_trace_plotter: pixel probes queue their expected colour and a monitor
// compares pixel_color two cycles later; FSM-side results are checked directly.
module tb_vga_trace_plotter;
`ifdef TRACE_GRID_EN
    localparam bit GRID_ON = 1'b1;
`else
    localparam bit GRID_ON = 1'b0;
`endif
    localparam logic [11:0] C0 = 12'hF00;
    localparam logic [11:0] C1 = 12'h0F0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic        active = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic [11:0] bg_color = '0;
    logic [23:0] trace_colors = {C1, C0};
    logic [11:0] sig_addr;
    logic [31:0] sig_data = '0;
    logic [11:0] pixel_color;
    logic        busy;
    logic [31:0] mem [4096];

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q [$];
    string       name_q [$];
    logic        probe = 1'b0, p1 = 1'b0, p2 = 1'b0;

    vga_trace_plotter dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .active       (active),
        .x            (x),
        .y            (y),
        .bg_color     (bg_color),
        .trace_colors (trace_colors),
        .sig_addr     (sig_addr),
        .sig_data     (sig_data),
        .pixel_color  (pixel_color),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) sig_data <= mem[sig_addr];

    always @(posedge clock) begin
        p1 <= probe;
        p2 <= p1;
    end

    // Monitor: a probe issued before edge N is visible on pixel_color after edge N+1.
    always @(posedge clock) begin
        #1;
        if (p2) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow got %h", pixel_color);
            end else begin
                logic [11:0] e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (pixel_color !== e) begin
                    errors++;
                    $display("FAIL %s got %h expected %h", n, pixel_color, e);
                end
            end
        end
    end

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic show(input string n, input int px, input int py, input logic act,
                        input logic [11:0] bg, input logic [11:0] exp);
        @(negedge clock);
        x = 10'(px);
        y = 9'(py);
        active = act;
        bg_color = bg;
        probe = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(n);
    endtask

    task automatic drain();
        @(negedge clock);
        probe = 1'b0;
        active = 1'b0;
        x = '0;
        y = '0;
        bg_color = '0;
        repeat (3) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic load(input int min0, input int max0);
        for (int i = 0; i < 4096; i++) mem[i] = 32'hABCDE000;
        mem['h6A9] = 32'hFFFFF000 | min0;
        mem['h6AA] = 32'h00000000;
        mem['h6AB] = 32'hFFFFF000 | max0;
        mem['h6AC] = 32'h12345FFF;
        for (int k = 0; k < 320; k++) begin
            mem['h559 + k] = 32'hABCDE000 | 600;
            mem['h6AD + k] = 32'hABCDE000 | 2048;
        end
        mem['h559 + 30] = 32'hABCDE000 | 50;
        mem['h6AD + 4]  = 32'hABCDE000;
        mem['h6AD + 5]  = 32'hABCDEFFF;
    endtask

    task automatic pulse_fs();
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20000) begin
            n++;
            @(negedge clock);
        end
        if (busy) begin
            errors++;
            $display("FAIL busy_timeout got busy=1 expected 0 within 20000 cycles");
        end
    endtask

    initial begin
        int n;
        load(100, 1100);
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_sig_addr", sig_addr, 0);
        check("reset_pixel", pixel_color, 0);
        reset = 1'b1;
        show("no_trace_before_frame", 65, 134, 1'b1, 12'h3C3, 12'h3C3);
        drain();

        // Frame 1: scaling, full-scale span and clamp.
        pulse_fs();
        wait_idle(n);
        check("busy_cycles", n, 14725);
        check("sig_addr_hold_idle", sig_addr, 'h7EC);
        show("scale_row134", 65, 134, 1'b1, 12'h001, C0);
        show("scale_row133", 65, 133, 1'b1, 12'h002, C0);
        show("scale_row135", 65, 135, 1'b1, 12'h003, C0);
        show("scale_row136_bg", 65, 136, 1'b1, 12'h004, 12'h004);
        show("scale_row137_bg", 65, 137, 1'b1, 12'h005, 12'h005);
        show("full_top", 60, 254, 1'b1, 12'h006, C1);
        show("full_mid", 60, 340, 1'b1, 12'h007, C1);
        show("full_bottom", 60, 433, 1'b1, 12'h008, C1);
        show("below_box1", 60, 434, 1'b1, 12'h009, 12'h009);
        show("between_boxes", 60, 253, 1'b1, 12'h00A, 12'h00A);
        show("clamp_row224", 85, 224, 1'b1, 12'h00B, C0);
        show("clamp_span_top", 85, 133, 1'b1, 12'h00C, C0);
        show("below_box0", 85, 225, 1'b1, 12'h00D, 12'h00D);
        show("grid_pixel", 75, 100, 1'b1, 12'h5A5, GRID_ON ? 12'h111 : 12'h5A5);
        show("inactive_black", 65, 134, 1'b0, 12'h00F, 12'h000);
        show("left_of_box", 54, 134, 1'b1, 12'h010, 12'h010);
        drain();

        // Frame 2: degenerate ch0 header, restarted in mid-FETCH.
        load(500, 500);
        pulse_fs();
        repeat (6) @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        check("restart_addr0", sig_addr, 'h6A9);
        check("restart_busy", busy, 1);
        @(negedge clock);
        check("restart_addr1", sig_addr, 'h6AA);
        @(negedge clock);
        check("restart_addr2", sig_addr, 'h6AB);
        @(negedge clock);
        check("restart_addr3", sig_addr, 'h6AC);
        show("busy_no_trace", 65, 224, 1'b1, 12'h020, 12'h020);
        drain();
        wait_idle(n);
        show("degen_row224", 65, 224, 1'b1, 12'h021, C0);
        show("degen_row223", 65, 223, 1'b1, 12'h022, C0);
        show("degen_row222_bg", 65, 222, 1'b1, 12'h023, 12'h023);
        show("degen_old_row_bg", 65, 134, 1'b1, 12'h024, 12'h024);
        show("degen_ch1_kept", 60, 300, 1'b1, 12'h025, C1);
        drain();

        // Asynchronous reset in mid-DIV.
        pulse_fs();
        active = 1'b1;
        x = '0;
        y = '0;
        bg_color = 12'hABC;
        repeat (12) @(negedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_pixel", pixel_color, 0);
        check("async_reset_sig_addr", sig_addr, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        active = 1'b0;
        show("after_reset_bg0", 65, 224, 1'b1, 12'h777, 12'h777);
        show("after_reset_bg1", 60, 300, 1'b1, 12'h778, 12'h778);
        drain();
        check("idle_after_reset", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
